// File: rtl/block_hit_judge_if.sv
// Interface bundling the judge's control inputs and score/status outputs.
//   master : drives start, shift_en, disp_num, keys; observes the score/status outputs
//   slave  : the judge itself
// Signals:
//   start      1-cycle pulse, IDLE/OVER -> PLAY
//   shift_en   generator shift pulse; disp_num already holds the shifted field
//   disp_num   64-bit block field, bottom row in [7:0], two bits per lane
//   keys       raw asynchronous lane buttons, active-high
//   score      16-bit saturating score
//   combo      consecutive hits, saturating at 255
//   max_combo  highest combo since start
//   lives      remaining lives
//   hit_mask   lanes of the current judge row already hit
//   hit_pulse  one cycle per cycle with at least one hit
//   miss_pulse one cycle per miss event
//   game_over  high while in OVER
//   score_bcd  4-digit BCD score (zero unless SCORE_BCD_EN)
interface block_hit_judge_if;
    logic        start;
    logic        shift_en;
    logic [63:0] disp_num;
    logic [3:0]  keys;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [1:0]  lives;
    logic [3:0]  hit_mask;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        game_over;
    logic [15:0] score_bcd;

    modport master (
        output start, shift_en, disp_num, keys,
        input  score, combo, max_combo, lives, hit_mask, hit_pulse, miss_pulse, game_over,
               score_bcd
    );

    modport slave (
        input  start, shift_en, disp_num, keys,
        output score, combo, max_combo, lives, hit_mask, hit_pulse, miss_pulse, game_over,
               score_bcd
    );
endinterface

// File: rtl/block_hit_judge.sv
// Scoring stage behind the falling-block generator. Each shift captures the bottom row of the
// field as the judge row; synchronised lane key presses are classified as hits (lane occupied)
// or wrong presses (lane empty); occupied lanes left unhit at the next shift are misses and
// cost a life. All outputs are registered.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  block_hit_judge_if.slave (inputs start/shift_en/disp_num/keys, score/status outputs)
// Parameters:
//   LIVES      lives loaded on start
//   BONUS_TH   combo value at/above which a hit earns bonus points
//   BONUS_PTS  extra points per hit while combo >= BONUS_TH
// Configuration:
//   SCORE_BCD_EN  when defined, score_bcd tracks the score as 4 BCD digits saturating at 9999;
//                 otherwise score_bcd is tied to zero.
module block_hit_judge #(
    parameter int unsigned LIVES     = 3,
    parameter int unsigned BONUS_TH  = 8,
    parameter int unsigned BONUS_PTS = 2
) (
    input logic              clk,
    input logic              rst,
    block_hit_judge_if.slave bus
);

    localparam logic [7:0] BonusTh   = 8'(BONUS_TH);
    localparam logic [7:0] BonusPts  = 8'(BONUS_PTS);
    localparam logic [1:0] LivesInit = 2'(LIVES);

    typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

    state_e      state_q;
    logic [3:0]  k1_q, k2_q, k3_q;
    logic [7:0]  row_q;
    logic [15:0] score_q;
    logic [7:0]  combo_q;
    logic [7:0]  max_combo_q;
    logic [1:0]  lives_q;
    logic [3:0]  hit_mask_q;
    logic        hit_pulse_q;
    logic        miss_pulse_q;

    logic [3:0]  press, occ, hits, wrong, miss;
    logic        miss_shift;
    logic [2:0]  n_hits;
    logic [7:0]  per_hit, gain;
    logic [16:0] score_sum;
    logic [15:0] score_next;
    logic [8:0]  combo_sum;
    logic [7:0]  combo_next, max_next;
    logic [1:0]  lives_next;

    // Only the bottom row of the field is judged.
    logic unused_disp;
    assign unused_disp = ^bus.disp_num[63:8];

    always_comb begin
        press = k2_q & ~k3_q;
        occ   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            occ[i] = |row_q[2*i +: 2];
        end
        // Lanes already hit in this row are masked out entirely: neither hit nor wrong.
        hits       = press & occ & ~hit_mask_q;
        wrong      = press & ~occ & ~hit_mask_q;
        miss       = occ & ~(hit_mask_q | hits);
        miss_shift = bus.shift_en & (|miss);

        n_hits  = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
        // Bonus eligibility uses the combo before this cycle's hits.
        per_hit = 8'd1 + ((combo_q >= BonusTh) ? BonusPts : 8'd0);
        gain    = 8'(n_hits) * per_hit;

        score_sum  = {1'b0, score_q} + {9'd0, gain};
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        combo_sum  = {1'b0, combo_q} + {6'd0, n_hits};
        combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        // Clear after the hit increments so a wrong/miss in the same cycle wins.
        if ((|wrong) || miss_shift) begin
            combo_next = 8'd0;
        end
        max_next   = (combo_next > max_combo_q) ? combo_next : max_combo_q;
        lives_next = (miss_shift && (lives_q != 2'd0)) ? lives_q - 2'd1 : lives_q;
    end

`ifdef SCORE_BCD_EN
    logic [15:0] bcd_q, bcd_next, add_bcd;
    logic [4:0]  digit_sum;
    logic        carry;

    always_comb begin
        add_bcd   = {4'd0, 4'(gain / 8'd100), 4'((gain / 8'd10) % 8'd10), 4'(gain % 8'd10)};
        bcd_next  = bcd_q;
        digit_sum = 5'd0;
        carry     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            digit_sum = {1'b0, bcd_q[4*i +: 4]} + {1'b0, add_bcd[4*i +: 4]} + {4'd0, carry};
            if (digit_sum >= 5'd10) begin
                bcd_next[4*i +: 4] = 4'(digit_sum - 5'd10);
                carry              = 1'b1;
            end else begin
                bcd_next[4*i +: 4] = digit_sum[3:0];
                carry              = 1'b0;
            end
        end
        if (carry) begin
            bcd_next = 16'h9999;
        end
    end

    assign bus.score_bcd = bcd_q;
`else
    assign bus.score_bcd = 16'h0000;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            k1_q         <= 4'd0;
            k2_q         <= 4'd0;
            k3_q         <= 4'd0;
            row_q        <= 8'd0;
            score_q      <= 16'd0;
            combo_q      <= 8'd0;
            max_combo_q  <= 8'd0;
            lives_q      <= 2'd0;
            hit_mask_q   <= 4'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
`ifdef SCORE_BCD_EN
            bcd_q        <= 16'd0;
`endif
        end else begin
            k1_q         <= bus.keys;
            k2_q         <= k1_q;
            k3_q         <= k2_q;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle, StOver: begin
                    if (bus.start) begin
                        state_q     <= StPlay;
                        lives_q     <= LivesInit;
                        score_q     <= 16'd0;
                        combo_q     <= 8'd0;
                        max_combo_q <= 8'd0;
                        hit_mask_q  <= 4'd0;
                        row_q       <= 8'd0;
`ifdef SCORE_BCD_EN
                        bcd_q       <= 16'd0;
`endif
                    end
                end
                StPlay: begin
                    score_q      <= score_next;
                    combo_q      <= combo_next;
                    max_combo_q  <= max_next;
                    lives_q      <= lives_next;
                    hit_pulse_q  <= |hits;
                    miss_pulse_q <= (|wrong) | miss_shift;
`ifdef SCORE_BCD_EN
                    bcd_q        <= bcd_next;
`endif
                    // Presses in a shift cycle were judged against the outgoing row above.
                    if (bus.shift_en) begin
                        row_q      <= bus.disp_num[7:0];
                        hit_mask_q <= 4'd0;
                    end else begin
                        hit_mask_q <= hit_mask_q | hits;
                    end
                    if (lives_next == 2'd0) begin
                        state_q <= StOver;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.max_combo  = max_combo_q;
    assign bus.lives      = lives_q;
    assign bus.hit_mask   = hit_mask_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.game_over  = (state_q == StOver);

endmodule
